// File: rtl/clk_en_pkg.sv
// Shared definitions for the multi-channel clock-enable generator.
package clk_en_pkg;

  // Largest channel count the generator is meant to be built with.
  localparam int MAX_CH = 16;

  // Effective divisor: a programmed 0 behaves like 1 (enable every cycle).
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    logic [31:0] r;
    if (d == 32'd0) begin
      r = 32'd1;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: a down-counter with an active divisor and a
// one-deep pending divisor that is committed at the next period boundary
// (terminal count while advancing, or a global sync).
module clk_en_chan
  import clk_en_pkg::*;
#(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(32'd4)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_en,
  output logic             pending
);

  // Counter value loaded at a period boundary for divisor d.
  function automatic logic [CNT_W-1:0] reload(input logic [CNT_W-1:0] d);
    return CNT_W'(eff_div(32'(d)) - 32'd1);
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] act_div_r;
  logic [CNT_W-1:0] pend_div_r;
  logic             pend_v_r;

  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] act_div_s;
  logic [CNT_W-1:0] pend_div_s;
  logic             pend_v_s;
  logic             terminal_s;
  logic             commit_s;

  // Next-state logic: boundary commit/reload, countdown, and pending capture.
  always_comb begin
    terminal_s = (cnt_r == {CNT_W{1'b0}});
    commit_s   = sync | (adv & terminal_s);
    cnt_s      = cnt_r;
    act_div_s  = act_div_r;
    pend_div_s = pend_div_r;
    pend_v_s   = pend_v_r;

    if (commit_s) begin
      if (pend_v_r) begin
        act_div_s = pend_div_r;
        cnt_s     = reload(pend_div_r);
      end else begin
        act_div_s = act_div_r;
        cnt_s     = reload(act_div_r);
      end
    end else if (adv) begin
      cnt_s = cnt_r - CNT_W'(32'd1);
    end else begin
      cnt_s = cnt_r;
    end

    // A write landing on a boundary cycle survives the commit of the old value.
    if (wr) begin
      pend_div_s = wr_div;
      pend_v_s   = 1'b1;
    end else if (commit_s) begin
      pend_v_s   = 1'b0;
    end else begin
      pend_v_s   = pend_v_r;
    end
  end

  // Channel state registers with asynchronous return to the default divisor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= reload(DEF_DIV);
      act_div_r  <= DEF_DIV;
      pend_div_r <= {CNT_W{1'b0}};
      pend_v_r   <= 1'b0;
    end else begin
      cnt_r      <= cnt_s;
      act_div_r  <= act_div_s;
      pend_div_r <= pend_div_s;
      pend_v_r   <= pend_v_s;
    end
  end

  // adv already excludes sync, so the pulse is a pure terminal decode.
  assign clk_en  = adv & terminal_s;
  assign pending = pend_v_r;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator: NUM_CH independent divided enable
// pulses with run-time divisors, global run/sync and a per-channel mask.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int                      NUM_CH       = 3,
  parameter int                      CNT_W        = 8,
  parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIVS = {8'd24, 8'd12, 8'd4},
  localparam int                     CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              sync,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] cfg_pending
);

  logic [NUM_CH-1:0] adv_s;
  logic [NUM_CH-1:0] wr_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Sync takes priority over advancing; out-of-range cfg_ch matches no channel.
    assign adv_s[i] = run & ch_en[i] & ~sync;
    assign wr_s[i]  = cfg_we & (32'(cfg_ch) == 32'(i));

    clk_en_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEFAULT_DIVS[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (adv_s[i]),
      .sync    (sync),
      .wr      (wr_s[i]),
      .wr_div  (cfg_div),
      .clk_en  (clk_en[i]),
      .pending (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
module tb_clk_en_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       sync;
  logic [2:0] ch_en;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [2:0] clk_en;
  logic [2:0] cfg_pending;

  always #5 clk = ~clk;

  clk_en_gen #(
    .NUM_CH       (3),
    .CNT_W        (8),
    .DEFAULT_DIVS ({8'd24, 8'd12, 8'd4})
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .sync        (sync),
    .ch_en       (ch_en),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .clk_en      (clk_en),
    .cfg_pending (cfg_pending)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: each channel tracks how many advancing cycles have
  // elapsed in the current period, its period, and an optional pending value.
  int m_period [3];
  int m_since  [3];
  int m_pend   [3];
  bit m_pend_v [3];
  int defaults [3] = '{4, 12, 24};

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_period[i] = defaults[i];
      m_since[i]  = 0;
      m_pend[i]   = 0;
      m_pend_v[i] = 1'b0;
    end
  endtask

  function automatic logic [2:0] model_clk_en();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i] = run && ch_en[i] && !sync && (m_since[i] == eff(m_period[i]) - 1);
    end
    return r;
  endfunction

  function automatic logic [2:0] model_pending();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = m_pend_v[i];
    return r;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit boundary;
      boundary = sync || (run && ch_en[i] && (m_since[i] == eff(m_period[i]) - 1));
      if (boundary) begin
        if (m_pend_v[i]) begin
          m_period[i] = m_pend[i];
          m_pend_v[i] = 1'b0;
        end
        m_since[i] = 0;
      end else if (run && ch_en[i]) begin
        m_since[i] = m_since[i] + 1;
      end
      if (cfg_we && (int'(cfg_ch) == i)) begin
        m_pend[i]   = int'(cfg_div);
        m_pend_v[i] = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [2:0] en,
                       input logic we, input logic [1:0] ch, input logic [7:0] dv);
    run = r; sync = s; ch_en = en; cfg_we = we; cfg_ch = ch; cfg_div = dv;
  endtask

  // One clock cycle: sample mid-cycle against the model, then advance both.
  task automatic tick(output logic [2:0] ce, output logic [2:0] pd);
    @(negedge clk);
    ce = clk_en;
    pd = cfg_pending;
    check("model_clk_en", 32'(ce), 32'(model_clk_en()));
    check("model_pending", 32'(pd), 32'(model_pending()));
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic       run;
    logic       sync;
    logic [2:0] ch_en;
    logic       we;
    logic [1:0] ch;
    logic [7:0] dv;
    logic [2:0] exp_ce;
    logic [2:0] exp_pd;
  } vec_t;

  vec_t tbl [26];

  task automatic run_table();
    logic [2:0] ce;
    logic [2:0] pd;
    for (int c = 0; c < 26; c++) begin
      drive(tbl[c].run, tbl[c].sync, tbl[c].ch_en, tbl[c].we, tbl[c].ch, tbl[c].dv);
      tick(ce, pd);
      check($sformatf("tbl_ce_c%0d", c), 32'(ce), 32'(tbl[c].exp_ce));
      check($sformatf("tbl_pd_c%0d", c), 32'(pd), 32'(tbl[c].exp_pd));
    end
  endtask

  logic [2:0] ce;
  logic [2:0] pd;
  int         n;

  initial begin
    // Defaults 4/12/24 from reset; ch0 reprogrammed to 6 in cycle 5.
    for (int c = 0; c < 26; c++) begin
      tbl[c].run    = 1'b1;
      tbl[c].sync   = 1'b0;
      tbl[c].ch_en  = 3'b111;
      tbl[c].we     = (c == 5);
      tbl[c].ch     = 2'd0;
      tbl[c].dv     = 8'd6;
      tbl[c].exp_ce = {(c == 23), (c == 11 || c == 23), (c inside {3, 7, 13, 19, 25})};
      tbl[c].exp_pd = {2'b00, (c == 6 || c == 7)};
    end

    model_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ce", 32'(clk_en), 32'd0);
    check("reset_pd", 32'(cfg_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Scenarios 1 and 2.
    run_table();

    // Scenario 4: hold with ch0 at count 2, then resume.
    drive(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0);
    repeat (3) tick(ce, pd);
    drive(1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0);
    for (int k = 0; k < 5; k++) begin
      tick(ce, pd);
      check("s4_held_ce", 32'(ce), 32'd0);
    end
    drive(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0);
    tick(ce, pd);
    check("s4_resume0", 32'(ce[0]), 32'd0);
    tick(ce, pd);
    check("s4_resume1", 32'(ce[0]), 32'd0);
    tick(ce, pd);
    check("s4_resume2", 32'(ce[0]), 32'd1);
    drive(1'b1, 1'b0, 3'b011, 1'b0, 2'd0, 8'd0);
    repeat (30) begin
      tick(ce, pd);
      check("s4_mask_ch2", 32'(ce[2]), 32'd0);
    end

    // Scenario 3: divisor 0 then 1 to ch1 (last wins), then sync.
    drive(1'b1, 1'b0, 3'b111, 1'b1, 2'd1, 8'd0);
    tick(ce, pd);
    drive(1'b1, 1'b0, 3'b111, 1'b1, 2'd1, 8'd1);
    tick(ce, pd);
    drive(1'b1, 1'b1, 3'b111, 1'b0, 2'd0, 8'd0);
    tick(ce, pd);
    check("s3_sync_ce", 32'(ce), 32'd0);
    drive(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      tick(ce, pd);
      check("s3_ch1_high", 32'(ce[1]), 32'd1);
    end

    // Scenario 5: ch2 pend 30, then sync together with a write of 10.
    drive(1'b1, 1'b0, 3'b111, 1'b1, 2'd2, 8'd30);
    tick(ce, pd);
    drive(1'b1, 1'b1, 3'b111, 1'b1, 2'd2, 8'd10);
    tick(ce, pd);
    check("s5_sync_ce", 32'(ce), 32'd0);
    drive(1'b1, 1'b0, 3'b111, 1'b1, 2'd3, 8'd5);
    tick(ce, pd);
    n = 1;
    check("s5_pend_after_sync", 32'(pd), 32'b100);
    drive(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0);
    while (!ce[2] && n < 40) begin
      tick(ce, pd);
      n++;
    end
    check("s5_first_gap", 32'(n), 32'd30);
    tick(ce, pd);
    n = 1;
    check("s5_pend_cleared", 32'(pd[2]), 32'd0);
    while (!ce[2] && n < 40) begin
      tick(ce, pd);
      n++;
    end
    check("s5_second_gap", 32'(n), 32'd10);

    // Scenario 6: asynchronous reset mid-count with a pending write.
    drive(1'b1, 1'b0, 3'b111, 1'b1, 2'd0, 8'd9);
    tick(ce, pd);
    drive(1'b1, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0);
    tick(ce, pd);
    check("s6_pend_before", 32'(pd[0]), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_ce", 32'(clk_en), 32'd0);
    check("s6_async_pd", 32'(cfg_pending), 32'd0);
    model_reset();
    drive(1'b0, 1'b0, 3'b111, 1'b0, 2'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_table();

    // Randomised traffic against the model.
    for (int k = 0; k < 600; k++) begin
      logic       r;
      logic       s;
      logic [2:0] en;
      logic       we;
      r  = ($urandom_range(0, 9) != 0);
      s  = ($urandom_range(0, 39) == 0);
      en = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
      we = ($urandom_range(0, 5) == 0);
      drive(r, s, en, we, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)));
      tick(ce, pd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
